// File: rtl/cpc_audio_pkg.sv
// Shared encodings and FSM state type for the CPC audio mixer.
// Pan bit 0 routes to the left bus and bit 1 routes to the right bus.
package cpc_audio_pkg;

  localparam logic [1:0] PAN_MUTE = 2'b00;
  localparam logic [1:0] PAN_L    = 2'b01;
  localparam logic [1:0] PAN_R    = 2'b10;
  localparam logic [1:0] PAN_LR   = 2'b11;

  localparam logic [3:0] GAIN_UNITY = 4'd8;
  localparam int         GAIN_SHIFT = $clog2(GAIN_UNITY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cpc_audio_sat.sv
// Unsigned saturator: clamps an IN_W-bit value to the OW-bit range.
// The caller must guarantee IN_W > OW.
module cpc_audio_sat
  import cpc_audio_pkg::*;
#(
  parameter int IN_W = 13,
  parameter int OW   = 8
) (
  input  logic [IN_W-1:0] din,
  output logic [OW-1:0]   dout
);

  localparam logic [IN_W-1:0] MAX_V = {{(IN_W-OW){1'b0}}, {OW{1'b1}}};

  // clamp to full-scale
  always_comb begin
    if (din > MAX_V) begin
      dout = {OW{1'b1}};
    end else begin
      dout = din[OW-1:0];
    end
  end

endmodule

// File: rtl/cpc_audio_mixer.sv
// Sequential NCH-channel stereo mixer with per-channel gain and pan, one shared
// multiplier stepped across the channels, and a registered output stage.
module cpc_audio_mixer
  import cpc_audio_pkg::*;
#(
  parameter int NCH = 3,
  parameter int IW  = 8,
  parameter int OW  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic [NCH*IW-1:0] ch_in,
  input  logic [NCH*4-1:0]  gain,
  input  logic [NCH*2-1:0]  pan,
  input  logic              mono,
  output logic [OW-1:0]     out_l,
  output logic [OW-1:0]     out_r,
  output logic              out_valid,
  output logic              overrun
);

  localparam int PW = IW + 4;
  localparam int AW = IW + 4 + $clog2(NCH + 1);
  localparam int XW = (NCH > 1) ? $clog2(NCH) : 1;

  state_t             state_r;
  state_t             state_s;
  logic [XW-1:0]      idx_r;
  logic [AW-1:0]      acc_l_r;
  logic [AW-1:0]      acc_r_r;
  logic [NCH*IW-1:0]  ch_r;
  logic [NCH*4-1:0]   gain_r;
  logic [NCH*2-1:0]   pan_r;
  logic               mono_r;
  logic [OW-1:0]      res_l_r;
  logic [OW-1:0]      res_r_r;
  logic               done_r;

  logic [IW-1:0]      ch_sel_s;
  logic [3:0]         gain_sel_s;
  logic [1:0]         pan_sel_s;
  logic [PW-1:0]      prod_s;
  logic [AW-1:0]      contrib_s;
  logic [AW-1:0]      sum_l_s;
  logic [AW-1:0]      sum_r_s;
  logic [AW:0]        mono_sum_s;
  logic [AW-1:0]      sat_in_l_s;
  logic [AW-1:0]      sat_in_r_s;
  logic [OW-1:0]      sat_l_s;
  logic [OW-1:0]      sat_r_s;
  logic               last_s;

  // operand select from the snapshot and the single shared multiplier
  always_comb begin
    ch_sel_s   = ch_r[int'(idx_r)*IW +: IW];
    gain_sel_s = gain_r[int'(idx_r)*4 +: 4];
    pan_sel_s  = pan_r[int'(idx_r)*2 +: 2];
    prod_s     = PW'(ch_sel_s) * PW'(gain_sel_s);
    contrib_s  = AW'(prod_s >> GAIN_SHIFT);
    last_s     = (idx_r == XW'(NCH - 1));
  end

  // pan routing into the two accumulator buses
  always_comb begin
    sum_l_s = acc_l_r;
    sum_r_s = acc_r_r;
    if ((pan_sel_s & PAN_L) != PAN_MUTE) begin
      sum_l_s = acc_l_r + contrib_s;
    end else begin
      sum_l_s = acc_l_r;
    end
    if ((pan_sel_s & PAN_R) != PAN_MUTE) begin
      sum_r_s = acc_r_r + contrib_s;
    end else begin
      sum_r_s = acc_r_r;
    end
  end

  // mono fold keeps one extra bit so the average cannot wrap
  always_comb begin
    mono_sum_s = {1'b0, acc_l_r} + {1'b0, acc_r_r};
    if (mono_r) begin
      sat_in_l_s = mono_sum_s[AW:1];
      sat_in_r_s = mono_sum_s[AW:1];
    end else begin
      sat_in_l_s = acc_l_r;
      sat_in_r_s = acc_r_r;
    end
  end

  cpc_audio_sat #(.IN_W(AW), .OW(OW)) u_sat_l (
    .din  (sat_in_l_s),
    .dout (sat_l_s)
  );

  cpc_audio_sat #(.IN_W(AW), .OW(OW)) u_sat_r (
    .din  (sat_in_r_s),
    .dout (sat_r_s)
  );

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (ce) begin
          state_s = ACC;
        end else begin
          state_s = IDLE;
        end
      end
      ACC: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = ACC;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // datapath registers, output stage and sticky overrun
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      idx_r     <= {XW{1'b0}};
      acc_l_r   <= {AW{1'b0}};
      acc_r_r   <= {AW{1'b0}};
      ch_r      <= {(NCH*IW){1'b0}};
      gain_r    <= {(NCH*4){1'b0}};
      pan_r     <= {(NCH*2){1'b0}};
      mono_r    <= 1'b0;
      res_l_r   <= {OW{1'b0}};
      res_r_r   <= {OW{1'b0}};
      done_r    <= 1'b0;
      out_l     <= {OW{1'b0}};
      out_r     <= {OW{1'b0}};
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_r   <= state_s;
      done_r    <= 1'b0;
      out_valid <= done_r;
      if (done_r) begin
        out_l <= res_l_r;
        out_r <= res_r_r;
      end
      if (ce && (state_r != IDLE)) begin
        overrun <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (ce) begin
            ch_r    <= ch_in;
            gain_r  <= gain;
            pan_r   <= pan;
            mono_r  <= mono;
            acc_l_r <= {AW{1'b0}};
            acc_r_r <= {AW{1'b0}};
            idx_r   <= {XW{1'b0}};
          end
        end
        ACC: begin
          acc_l_r <= sum_l_s;
          acc_r_r <= sum_r_s;
          if (!last_s) begin
            idx_r <= idx_r + XW'(1);
          end
        end
        DONE: begin
          res_l_r <= sat_l_s;
          res_r_r <= sat_r_s;
          done_r  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cpc_audio_mixer.md
CPC_AUDIO_MIXER -- requirements
Module: cpc_audio_mixer

Interface
REQ-001 SHALL have parameter NCH, default 3: number of input channels, 1..8.
REQ-002 SHALL have parameter IW, default 8: unsigned channel sample width.
REQ-003 SHALL have parameter OW, default 8: unsigned output sample width, OW <= IW+4.
REQ-004 SHALL have a single clock and a synchronous, active-high reset; both are listed first below.
REQ-005 SHALL have port clk, input, 1 bit: system clock.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port ce, input, 1 bit: sample strobe, one clk wide.
REQ-008 SHALL have port ch_in, input, NCH*IW bits: channel samples; channel k occupies bits [k*IW+:IW].
REQ-009 SHALL have port gain, input, NCH*4 bits: per-channel gain g, 0..15; 8 is unity.
REQ-010 SHALL have port pan, input, NCH*2 bits: per-channel routing; 00 mute, 01 left, 10 right, 11 both.
REQ-011 SHALL have port mono, input, 1 bit: fold left and right into one signal.
REQ-012 SHALL have port out_l, output, OW bits: left mix.
REQ-013 SHALL have port out_r, output, OW bits: right mix.
REQ-014 SHALL have port out_valid, output, 1 bit: one-clk pulse when a new mix is presented.
REQ-015 SHALL have port overrun, output, 1 bit: sticky flag, set when ce arrives while a mix is in progress.

Function
REQ-016 SHALL implement the FSM states IDLE, ACC and DONE.
REQ-017 In IDLE with ce=1, SHALL snapshot ch_in, gain, pan and mono into shadow registers, clear both accumulators, set idx=0 and go to ACC.
REQ-018 In ACC, SHALL compute c = (ch[idx]*g[idx])>>3 for one channel per clk, with truncation per channel.
REQ-019 In ACC, SHALL add c to the left accumulator if pan[idx][0]=1 and to the right accumulator if pan[idx][1]=1.
REQ-020 In ACC, SHALL increment idx, or go to DONE when idx equals NCH-1.
REQ-021 Accumulator width SHALL be IW+4+clog2(NCH+1) bits so that no intermediate sum can wrap.
REQ-022 In DONE with mono=0, SHALL register out_l = sat(accL) and out_r = sat(accR).
REQ-023 In DONE with mono=1, SHALL register out_l = out_r = sat((accL+accR)>>1).
REQ-024 sat(x) SHALL equal x if x <= 2^OW-1, and 2^OW-1 otherwise.
REQ-025 In DONE, SHALL assert out_valid for one clk and return to IDLE.
REQ-026 Latency: out_valid and the new outputs SHALL appear exactly NCH+2 clk edges after the edge at which ce is sampled.
REQ-027 Outputs SHALL hold their values between mixes.
REQ-028 A ce in ACC or DONE SHALL be ignored and SHALL set overrun; no restart occurs and no mix is queued.
REQ-029 A ce in the same clk as the DONE-to-IDLE transition SHALL be treated as overrun, since it is sampled in DONE.
REQ-030 Changes to ch_in, gain, pan or mono after the snapshot SHALL NOT affect the mix in progress.
REQ-031 With defaults and gains A=4, B=2, C=4 and pans A=01, B=11, C=10, out_l SHALL equal A/2+B/4 and out_r SHALL equal C/2+B/4, both floor, matching the existing CPC mix.

Reset
REQ-032 When reset=1 at a clk edge, SHALL force state IDLE, idx=0, both accumulators 0, out_l=0, out_r=0, out_valid=0 and overrun=0.
REQ-033 Reset SHALL take priority over ce and over any state, including a mix in progress, which is discarded without an out_valid pulse.
REQ-034 overrun SHALL be cleared only by reset.

Structure
REQ-035 Package cpc_audio_pkg SHALL hold the pan encodings (PAN_MUTE, PAN_L, PAN_R, PAN_LR), GAIN_UNITY=8 and the FSM state typedef.
REQ-036 The saturator SHALL be the single sub-module cpc_audio_sat, parametrised by input width and OW, purely combinational.
REQ-037 The multiply SHALL be one shared IW x 4 multiplier, time-multiplexed over idx; there SHALL NOT be one multiplier per channel.

Verification
REQ-038 Legacy mix: NCH=3, A=B=0xFF, C=0, gains 4/2/4, pans 01/11/10 -> out_l=0xBE, out_r=0x3F, out_valid high exactly 5 clks after ce.
REQ-039 Saturation: all channels 0xFF, all gains 15, all pans 11 -> out_l=out_r=0xFF, and no wrap occurs.
REQ-040 Mono: legacy-mix stimulus with mono=1 -> out_l=out_r=0x7E.
REQ-041 Overrun and snapshot: second ce 2 clks after the first, with ch_in changed to 0 at that point -> first result unchanged, a single out_valid pulse, overrun=1 held until reset.
REQ-042 Reset mid-op: reset asserted 2 clks after ce -> no out_valid pulse, outputs=0, overrun=0; a following ce gives a correct mix.
REQ-043 Parameter sweep: NCH=1 and NCH=8, OW=10, random stimulus compared against a reference model -> exact match and latency NCH+2.
